// File: rtl/num_in_arbiter_pkg.sv
// Shared definitions for the switch-entry arbiter: FSM encoding,
// requester IDs and a small one-hot helper.
package num_in_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ARM        = 3'd1,
    ST_WAIT_PRESS = 3'd2,
    ST_DONE       = 3'd3,
    ST_FAIL       = 3'd4
  } state_t;

  localparam int REQ_CPU = 0;
  localparam int REQ_DBG = 1;

  // Turn a requester ID into its one-hot grant/ack/err bit pattern.
  function automatic logic [1:0] onehot2(input logic id);
    logic [1:0] v;
    v = '0;
    v[id] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/num_in_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker. With a single request that
// requester wins; with both requesting, the one that was not served last wins.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner,
  output logic       valid
);

  // Pick the winner from the request pair and the last-served ID.
  always_comb begin
    winner = 1'b0;
    valid  = |req;
    if (req == 2'b11) begin
      winner = ~last;
    end else begin
      winner = req[1];
    end
  end

endmodule

// File: rtl/num_in_arbiter.sv
// Shares the switch bank and debounced confirm key between two requesters.
// A granted requester waits for the user to release and then press the key;
// the switch value is latched on the press and returned with a one-cycle ack.
//
// Handshake: req[i] is a level held by requester i until it sees ack[i] or
// err[i] (one-cycle pulses); it must drop req[i] in that pulse cycle or the
// cycle after. Dropping req[i] early while waiting for the user aborts the
// transaction silently. data_out is valid in the ack cycle and holds until
// the next successful transaction.
module num_in_arbiter
  import num_in_arbiter_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 0,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [DATA_W-1:0] num_in,
  input  logic              num_clk,
  output logic [1:0]        grant,
  output logic              block,
  output logic [DATA_W-1:0] data_out,
  output logic [1:0]        ack,
  output logic [1:0]        err
);

  // Last counter value before the transaction times out; unused when TIMEOUT=0.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam bit               TMO_EN   = (TIMEOUT != 0);

  state_t           state;
  logic             gid;
  logic             rr_last;
  logic [CNT_W-1:0] cnt;
  logic             pick_winner;
  logic             pick_valid;

  rr_pick2 u_pick (
    .req    (req),
    .last   (rr_last),
    .winner (pick_winner),
    .valid  (pick_valid)
  );

  // The echo digits are lit only while the user is expected to act.
  assign block = (state == ST_ARM) || (state == ST_WAIT_PRESS);

  // Arbitration FSM with timeout counter, value latch and registered pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      gid      <= 1'b0;
      rr_last  <= 1'b1;
      cnt      <= '0;
      grant    <= '0;
      ack      <= '0;
      err      <= '0;
      data_out <= '0;
    end else begin
      ack <= '0;
      err <= '0;
      case (state)
        ST_IDLE: begin
          // num_clk is deliberately ignored here.
          if (pick_valid) begin
            state <= ST_ARM;
            gid   <= pick_winner;
            grant <= onehot2(pick_winner);
          end
        end
        ST_ARM: begin
          // A key still held from the previous entry must be released first.
          if (!req[gid]) begin
            state <= ST_IDLE;
            grant <= '0;
          end else if (!num_clk) begin
            state <= ST_WAIT_PRESS;
            cnt   <= '0;
          end
        end
        ST_WAIT_PRESS: begin
          if (!req[gid]) begin
            state <= ST_IDLE;
            grant <= '0;
          end else if (num_clk) begin
            // Key press wins over a timeout in the same cycle.
            data_out <= num_in;
            ack      <= onehot2(gid);
            rr_last  <= gid;
            state    <= ST_DONE;
          end else if (TMO_EN && (cnt == CNT_LAST)) begin
            err     <= onehot2(gid);
            rr_last <= gid;
            state   <= ST_FAIL;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DONE, ST_FAIL: begin
          state <= ST_IDLE;
          grant <= '0;
        end
        default: begin
          state <= ST_IDLE;
          grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_num_in_arbiter.sv
// Directed bench for num_in_arbiter (TIMEOUT=5). Expected ack/err responses
// are queued when stimulus is issued; a negedge monitor pops and compares
// whenever the DUT pulses ack or err.
module tb_num_in_arbiter;

  localparam int DATA_W = 8;
  localparam int RESP_W = 4 + DATA_W;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        req;
  logic [DATA_W-1:0] num_in;
  logic              num_clk;
  logic [1:0]        grant;
  logic              block;
  logic [DATA_W-1:0] data_out;
  logic [1:0]        ack;
  logic [1:0]        err;

  logic [RESP_W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  num_in_arbiter #(.DATA_W(DATA_W), .TIMEOUT(5), .CNT_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .num_in   (num_in),
    .num_clk  (num_clk),
    .grant    (grant),
    .block    (block),
    .data_out (data_out),
    .ack      (ack),
    .err      (err)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_resp(input logic [1:0] e_err, input logic [1:0] e_ack,
                             input logic [DATA_W-1:0] e_data);
    exp_q.push_back({e_err, e_ack, e_data});
  endtask

  // Scoreboard monitor: every ack/err pulse must match the oldest expectation.
  always @(negedge clk) begin
    logic [RESP_W-1:0] e;
    if (!rst && ((ack != 2'b00) || (err != 2'b00))) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_resp: got err=%b ack=%b data=%0h, none expected at %0t",
                 err, ack, data_out, $time);
      end else begin
        e = exp_q.pop_front();
        if ({err, ack, data_out} !== e) begin
          bad++;
          $display("FAIL resp: got err=%b ack=%b data=%0h expected err=%b ack=%b data=%0h at %0t",
                   err, ack, data_out, e[RESP_W-1 -: 2], e[RESP_W-3 -: 2], e[DATA_W-1:0], $time);
        end
      end
    end
  end

  // Stimulus
  initial begin
    rst = 1'b1; req = 2'b00; num_in = '0; num_clk = 1'b0;
    repeat (3) tick();
    check("rst_grant", 16'(grant), 16'h0);
    check("rst_block", 16'(block), 16'h0);
    check("rst_ack_err", 16'({ack, err}), 16'h0);
    check("rst_data", 16'(data_out), 16'h0);
    rst = 1'b0;
    tick();

    // Fairness: both request, 0 wins first, then 1.
    req = 2'b11; num_in = 8'h11;
    tick();
    check("fair_grant0", 16'(grant), 16'h1);
    tick();
    num_clk = 1'b1; expect_resp(2'b00, 2'b01, 8'h11);
    tick();
    check("fair_ack0", 16'(ack), 16'h1);
    check("fair_data0", 16'(data_out), 16'h11);
    num_clk = 1'b0; num_in = 8'h22;
    tick();
    check("fair_gap", 16'(grant), 16'h0);
    tick();
    check("fair_grant1", 16'(grant), 16'h2);
    tick();
    num_clk = 1'b1; expect_resp(2'b00, 2'b10, 8'h22);
    tick();
    check("fair_ack1", 16'(ack), 16'h2);
    check("fair_data1", 16'(data_out), 16'h22);
    req = 2'b00; num_clk = 1'b0;
    tick();
    check("fair_end", 16'(grant), 16'h0);

    // Single CPU request.
    req = 2'b01; num_in = 8'hA5;
    tick();
    check("cpu_grant", 16'(grant), 16'h1);
    check("cpu_block", 16'(block), 16'h1);
    tick();
    num_clk = 1'b1; expect_resp(2'b00, 2'b01, 8'hA5);
    tick();
    check("cpu_ack", 16'(ack), 16'h1);
    check("cpu_data", 16'(data_out), 16'hA5);
    check("cpu_block_done", 16'(block), 16'h0);
    req = 2'b00; num_clk = 1'b0;
    tick();
    check("cpu_release", 16'(grant), 16'h0);

    // Held key across a completed transaction and a new DBG request.
    req = 2'b01; num_in = 8'h33;
    tick();
    tick();
    num_clk = 1'b1; expect_resp(2'b00, 2'b01, 8'h33);
    tick();
    check("held_ack0", 16'(ack), 16'h1);
    req = 2'b10; num_in = 8'h44;
    tick();
    tick();
    check("held_grant", 16'(grant), 16'h2);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("held_block", 16'(block), 16'h1);
      check("held_noack", 16'(ack), 16'h0);
    end
    num_clk = 1'b0;
    tick();
    num_clk = 1'b1; expect_resp(2'b00, 2'b10, 8'h44);
    tick();
    check("held_ack1", 16'(ack), 16'h2);
    check("held_data", 16'(data_out), 16'h44);
    req = 2'b00; num_clk = 1'b0;
    tick();

    // Abort: req drops in WAIT_PRESS together with a key press.
    req = 2'b01;
    tick();
    tick();
    tick();
    req = 2'b00; num_clk = 1'b1; num_in = 8'hFF;
    tick();
    check("abort_grant", 16'(grant), 16'h0);
    check("abort_block", 16'(block), 16'h0);
    tick();
    tick();
    check("abort_noack", 16'(ack), 16'h0);
    check("abort_data", 16'(data_out), 16'h44);
    num_clk = 1'b0;
    tick();

    // Timeout: key never pressed.
    req = 2'b10;
    tick();
    tick();
    check("tmo_block", 16'(block), 16'h1);
    expect_resp(2'b10, 2'b00, 8'h44);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("tmo_early", 16'(err), 16'h0);
    end
    tick();
    check("tmo_err", 16'(err), 16'h2);
    check("tmo_grant", 16'(grant), 16'h2);
    check("tmo_data", 16'(data_out), 16'h44);
    req = 2'b00;
    tick();
    check("tmo_release", 16'({grant, err}), 16'h0);

    // Key press in the expiring cycle wins over the timeout.
    req = 2'b10; num_in = 8'h5A;
    tick();
    tick();
    for (int i = 0; i < 4; i++) tick();
    num_clk = 1'b1; expect_resp(2'b00, 2'b10, 8'h5A);
    tick();
    check("race_ack", 16'(ack), 16'h2);
    check("race_err", 16'(err), 16'h0);
    req = 2'b00; num_clk = 1'b0;
    tick();

    // Asynchronous reset mid-WAIT_PRESS.
    req = 2'b01; num_in = 8'h77;
    tick();
    tick();
    check("arst_pre_block", 16'(block), 16'h1);
    #2 rst = 1'b1;
    #1;
    check("arst_grant", 16'(grant), 16'h0);
    check("arst_block", 16'(block), 16'h0);
    check("arst_ack_err", 16'({ack, err}), 16'h0);
    check("arst_data", 16'(data_out), 16'h0);
    req = 2'b00;
    tick();
    rst = 1'b0;
    tick();

    check("queue_empty", 16'(exp_q.size()), 16'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
